// File: rtl/framebuffer_pkg.sv
// framebuffer_pkg: shared clear-engine states and derived width helpers
package framebuffer_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, FILL} state_t;
  function automatic int pixel_width(input int nsp, input int spw);
    return nsp * spw;
  endfunction
  function automatic int mask_width(input int ppb, input int nsp);
    return ppb * nsp;
  endfunction
  function automatic int mem_addr_width(input int fb_lg, input int ppb);
    return fb_lg - $clog2(ppb);
  endfunction
endpackage

// File: rtl/framebuffer_beat_mask_gen.sv
// framebuffer_beat_mask_gen: per-pixel sub-pixel write mask for one RAM beat
module framebuffer_beat_mask_gen
  import framebuffer_pkg::*;
#(
  parameter int PPB = 2,
  parameter int NSP = 4,
  parameter int XW = 11
) (
  input  logic [XW-1:0]                   beat_x,
  input  logic [XW-1:0]                   start_x,
  input  logic [XW-1:0]                   end_x,
  input  logic [NSP-1:0]                  mask,
  output logic [mask_width(PPB, NSP)-1:0] beat_mask
);
  for (genvar i = 0; i < PPB; i++) begin : g_px
    logic [XW:0] px;
    assign px = {1'b0, beat_x} + (XW+1)'(i);
    assign beat_mask[i*NSP +: NSP] = px >= {1'b0, start_x} && px < {1'b0, end_x} ? mask : '0;
  end
endmodule

// File: rtl/framebuffer_scissor_clear.sv
// framebuffer_scissor_clear: fills the screen or a clipped scissor rectangle with a colour, one RAM word per cycle
module framebuffer_scissor_clear
  import framebuffer_pkg::*;
#(
  parameter int NUMBER_OF_PIXELS_PER_BEAT = 2,
  parameter int NUMBER_OF_SUB_PIXELS = 4,
  parameter int SUB_PIXEL_WIDTH = 8,
  parameter int X_BIT_WIDTH = 11,
  parameter int Y_BIT_WIDTH = 11,
  parameter int FRAMEBUFFER_SIZE_IN_PIXEL_LG = 18,
  localparam int PIXEL_WIDTH = pixel_width(NUMBER_OF_SUB_PIXELS, SUB_PIXEL_WIDTH),
  localparam int MEM_ADDR_WIDTH = mem_addr_width(FRAMEBUFFER_SIZE_IN_PIXEL_LG, NUMBER_OF_PIXELS_PER_BEAT),
  localparam int MASK_WIDTH = mask_width(NUMBER_OF_PIXELS_PER_BEAT, NUMBER_OF_SUB_PIXELS)
) (
  input  logic                                            clk,
  input  logic                                            reset,
  input  logic                                            apply,
  output logic                                            applied,
  input  logic [PIXEL_WIDTH-1:0]                          confClearColor,
  input  logic                                            confEnableScissor,
  input  logic [X_BIT_WIDTH-1:0]                          confScissorStartX,
  input  logic [X_BIT_WIDTH-1:0]                          confScissorEndX,
  input  logic [Y_BIT_WIDTH-1:0]                          confScissorStartY,
  input  logic [Y_BIT_WIDTH-1:0]                          confScissorEndY,
  input  logic [X_BIT_WIDTH-1:0]                          confXResolution,
  input  logic [Y_BIT_WIDTH-1:0]                          confYResolution,
  input  logic [NUMBER_OF_SUB_PIXELS-1:0]                 confMask,
  output logic                                            writeEnablePort,
  output logic [MEM_ADDR_WIDTH-1:0]                       writeAddrPort,
  output logic [NUMBER_OF_PIXELS_PER_BEAT*PIXEL_WIDTH-1:0] writeDataPort,
  output logic [MASK_WIDTH-1:0]                           writeMaskPort,
  input  logic                                            writeReady
);
  localparam int PPB = NUMBER_OF_PIXELS_PER_BEAT;
  localparam int PPB_LG = $clog2(PPB);
  localparam int FB_LG = FRAMEBUFFER_SIZE_IN_PIXEL_LG;
  localparam int XW = X_BIT_WIDTH;
  localparam int YW = Y_BIT_WIDTH;
  state_t state, next_state;
  logic hold, scissor, empty, accept, row_last, last_row;
  logic [PIXEL_WIDTH-1:0] color;
  logic [NUMBER_OF_SUB_PIXELS-1:0] mask, fill_mask;
  logic [XW-1:0] c_sx, c_ex, c_xres, x_start, x_end, x_align, sx, ex, x0, bx;
  logic [YW-1:0] c_sy, c_ey, c_yres, y_start, y_end, ey, y;
  logic [FB_LG-1:0] row_base;
  assign x_start = scissor ? c_sx : '0;
  assign x_end = scissor && c_ex < c_xres ? c_ex : c_xres;
  assign y_start = scissor ? c_sy : '0;
  assign y_end = scissor && c_ey < c_yres ? c_ey : c_yres;
  assign x_align = x_start & ~XW'(PPB - 1);
  assign empty = x_start >= x_end || y_start >= y_end;
  assign accept = state == FILL && writeReady;
  assign row_last = {1'b0, bx} + (XW+1)'(PPB) >= {1'b0, ex};
  assign last_row = {1'b0, y} + (YW+1)'(1) >= {1'b0, ey};
  // an empty region spends one extra idle cycle with applied low before re-arming
  assign applied = state == IDLE && !hold;
  assign writeEnablePort = state == FILL;
  assign writeAddrPort = MEM_ADDR_WIDTH'((row_base + FB_LG'(bx)) >> PPB_LG);
  assign writeDataPort = {PPB{color}};
  assign fill_mask = state == FILL ? mask : '0;
  always_comb begin
    next_state = state == IDLE  ? (apply && !hold ? SETUP : IDLE)
               : state == SETUP ? (empty ? IDLE : FILL)
               : accept && row_last && last_row ? IDLE : FILL;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      hold <= 1'b0;
      scissor <= 1'b0;
      color <= '0;
      mask <= '0;
      c_sx <= '0;
      c_ex <= '0;
      c_sy <= '0;
      c_ey <= '0;
      c_xres <= '0;
      c_yres <= '0;
      sx <= '0;
      ex <= '0;
      x0 <= '0;
      bx <= '0;
      ey <= '0;
      y <= '0;
      row_base <= '0;
    end else begin
      state <= next_state;
      hold <= state == SETUP && empty;
      if (state == IDLE && apply && !hold) begin
        scissor <= confEnableScissor;
        color <= confClearColor;
        mask <= confMask;
        c_sx <= confScissorStartX;
        c_ex <= confScissorEndX;
        c_sy <= confScissorStartY;
        c_ey <= confScissorEndY;
        c_xres <= confXResolution;
        c_yres <= confYResolution;
      end
      if (state == SETUP) begin
        sx <= x_start;
        ex <= x_end;
        x0 <= x_align;
        bx <= x_align;
        ey <= y_end;
        y <= y_start;
        row_base <= FB_LG'(y_start) * FB_LG'(c_xres);
      end else if (accept) begin
        bx <= row_last ? x0 : bx + XW'(PPB);
        y <= row_last ? y + YW'(1) : y;
        row_base <= row_last ? row_base + FB_LG'(c_xres) : row_base;
      end
    end
  end
  framebuffer_beat_mask_gen #(
    .PPB(PPB),
    .NSP(NUMBER_OF_SUB_PIXELS),
    .XW(XW)
  ) u_mask (
    .beat_x(bx),
    .start_x(sx),
    .end_x(ex),
    .mask(fill_mask),
    .beat_mask(writeMaskPort)
  );
endmodule

// File: tb/tb_framebuffer_scissor_clear.sv
// tb_framebuffer_scissor_clear: directed vector bench for the scissor clear engine (PPB=2, 8x4 screen)
module tb_framebuffer_scissor_clear;
  localparam logic [31:0] COLOR = 32'hA1B2C3D4;
  typedef struct {
    logic en;
    int sx, ex, sy, ey;
    logic [3:0] m;
    int n, fa, fm, la, lm;
  } vec_t;
  logic clk = 1'b0, reset = 1'b1, apply = 1'b0, writeReady = 1'b1, confEnableScissor = 1'b0;
  logic [31:0] confClearColor = '0;
  logic [10:0] confScissorStartX = '0, confScissorEndX = '0, confScissorStartY = '0, confScissorEndY = '0;
  logic [10:0] confXResolution = 11'd8, confYResolution = 11'd4;
  logic [3:0] confMask = 4'hF;
  logic writeEnablePort, applied;
  logic [16:0] writeAddrPort;
  logic [63:0] writeDataPort;
  logic [7:0] writeMaskPort;
  int checks = 0, failures = 0;
  int got_addr[$];
  int got_mask[$];
  logic [63:0] got_data[$];
  int first_cyc, last_cyc, done_cyc, hold_err;
  vec_t vecs[11];

  framebuffer_scissor_clear dut (
    .clk(clk), .reset(reset), .apply(apply), .applied(applied),
    .confClearColor(confClearColor), .confEnableScissor(confEnableScissor),
    .confScissorStartX(confScissorStartX), .confScissorEndX(confScissorEndX),
    .confScissorStartY(confScissorStartY), .confScissorEndY(confScissorEndY),
    .confXResolution(confXResolution), .confYResolution(confYResolution),
    .confMask(confMask), .writeEnablePort(writeEnablePort), .writeAddrPort(writeAddrPort),
    .writeDataPort(writeDataPort), .writeMaskPort(writeMaskPort), .writeReady(writeReady)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_conf(input logic en, input int sx, ex, sy, ey, input logic [3:0] m,
                            input logic [31:0] col, input int xr, yr);
    confEnableScissor = en;
    confScissorStartX = 11'(sx);
    confScissorEndX = 11'(ex);
    confScissorStartY = 11'(sy);
    confScissorEndY = 11'(ey);
    confMask = m;
    confClearColor = col;
    confXResolution = 11'(xr);
    confYResolution = 11'(yr);
  endtask

  // cycle 0 = apply cycle; conf is scrambled right after apply to prove it was captured
  task automatic do_clear(input logic en, input int sx, ex, sy, ey, input logic [3:0] m,
                          input int st0, st1, input logic spam);
    logic [89:0] prev;
    logic prev_stall;
    got_addr.delete();
    got_mask.delete();
    got_data.delete();
    first_cyc = -1;
    last_cyc = -1;
    done_cyc = -1;
    hold_err = 0;
    prev_stall = 1'b0;
    prev = '0;
    @(posedge clk); #1;
    drive_conf(en, sx, ex, sy, ey, m, COLOR, 8, 4);
    apply = 1'b1;
    @(posedge clk); #1;
    apply = 1'b0;
    drive_conf(~en, 0, 1, 0, 1, 4'h0, 32'h0, 2, 2);
    for (int c = 1; c < 200; c++) begin
      apply = spam && (c == 3 || c == 4);
      writeReady = !(c >= st0 && c <= st1);
      @(negedge clk);
      if (prev_stall && {writeEnablePort, writeAddrPort, writeMaskPort, writeDataPort} !== prev) hold_err++;
      prev = {writeEnablePort, writeAddrPort, writeMaskPort, writeDataPort};
      prev_stall = writeEnablePort && !writeReady;
      if (applied) begin
        done_cyc = c;
        break;
      end
      if (writeEnablePort) begin
        if (first_cyc < 0) first_cyc = c;
        if (writeReady) begin
          got_addr.push_back(int'(writeAddrPort));
          got_mask.push_back(int'(writeMaskPort));
          got_data.push_back(writeDataPort);
          last_cyc = c;
        end
      end
      @(posedge clk); #1;
    end
    apply = 1'b0;
    writeReady = 1'b1;
    if (done_cyc < 0) begin
      checks++;
      failures++;
      $display("FAIL clear timeout: applied never returned high");
    end
  endtask

  initial begin
    int bad_data, bad_order, bad_seq;
    vecs[0]  = '{1'b0, 0, 0, 0, 0, 4'hF, 16, 0, 'hFF, 15, 'hFF};
    vecs[1]  = '{1'b1, 3, 6, 1, 3, 4'hF, 4, 5, 'hF0, 10, 'hFF};
    vecs[2]  = '{1'b1, 2, 2, 2, 3, 4'hF, 0, 0, 0, 0, 0};
    vecs[3]  = '{1'b0, 0, 0, 0, 0, 4'h5, 16, 0, 'h55, 15, 'h55};
    vecs[4]  = '{1'b1, 0, 20, 0, 10, 4'hF, 16, 0, 'hFF, 15, 'hFF};
    vecs[5]  = '{1'b1, 1, 8, 3, 4, 4'hF, 4, 12, 'hF0, 15, 'hFF};
    vecs[6]  = '{1'b1, 5, 6, 0, 1, 4'hF, 1, 2, 'hF0, 2, 'hF0};
    vecs[7]  = '{1'b1, 4, 5, 1, 2, 4'hF, 1, 6, 'h0F, 6, 'h0F};
    vecs[8]  = '{1'b1, 6, 3, 0, 2, 4'hF, 0, 0, 0, 0, 0};
    vecs[9]  = '{1'b1, 0, 8, 4, 6, 4'hF, 0, 0, 0, 0, 0};
    vecs[10] = '{1'b1, 0, 8, 0, 4, 4'h8, 16, 0, 'h88, 15, 'h88};

    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset applied", applied, 1);
    chk("reset we", writeEnablePort, 0);
    chk("reset addr", writeAddrPort, 0);
    chk("reset mask", writeMaskPort, 0);
    chk("reset data", writeDataPort, 0);
    reset = 1'b0;

    foreach (vecs[i]) begin
      do_clear(vecs[i].en, vecs[i].sx, vecs[i].ex, vecs[i].sy, vecs[i].ey, vecs[i].m, 0, -1, 1'b0);
      chk($sformatf("v%0d count", i), got_addr.size(), vecs[i].n);
      chk($sformatf("v%0d first we cycle", i), first_cyc, vecs[i].n > 0 ? 2 : -1);
      chk($sformatf("v%0d applied cycle", i), done_cyc, vecs[i].n > 0 ? vecs[i].n + 2 : 3);
      if (got_addr.size() == vecs[i].n && vecs[i].n > 0) begin
        chk($sformatf("v%0d first addr", i), got_addr[0], vecs[i].fa);
        chk($sformatf("v%0d first mask", i), got_mask[0], vecs[i].fm);
        chk($sformatf("v%0d last addr", i), got_addr[vecs[i].n-1], vecs[i].la);
        chk($sformatf("v%0d last mask", i), got_mask[vecs[i].n-1], vecs[i].lm);
      end
      bad_data = 0;
      bad_order = 0;
      foreach (got_data[k]) if (got_data[k] !== {COLOR, COLOR}) bad_data++;
      for (int k = 1; k < got_addr.size(); k++) if (got_addr[k] <= got_addr[k-1]) bad_order++;
      chk($sformatf("v%0d bad data words", i), bad_data, 0);
      chk($sformatf("v%0d out-of-order addrs", i), bad_order, 0);
    end

    do_clear(1'b1, 3, 6, 1, 3, 4'hF, 0, -1, 1'b0);
    chk("scissor seq count", got_addr.size(), 4);
    if (got_addr.size() == 4) begin
      chk("scissor seq addr1", got_addr[1], 6);
      chk("scissor seq mask1", got_mask[1], 'hFF);
      chk("scissor seq addr2", got_addr[2], 9);
      chk("scissor seq mask2", got_mask[2], 'hF0);
    end

    do_clear(1'b0, 0, 0, 0, 0, 4'hF, 4, 6, 1'b0);
    bad_seq = 0;
    foreach (got_addr[k]) if (got_addr[k] != k) bad_seq++;
    chk("stall count", got_addr.size(), 16);
    chk("stall addr sequence errors", bad_seq, 0);
    chk("stall held output changes", hold_err, 0);
    chk("stall last write cycle", last_cyc, 20);
    chk("stall applied cycle", done_cyc, 21);

    do_clear(1'b0, 0, 0, 0, 0, 4'hF, 0, -1, 1'b1);
    chk("busy apply count", got_addr.size(), 16);
    chk("busy apply applied cycle", done_cyc, 18);

    @(posedge clk); #1;
    drive_conf(1'b0, 0, 0, 0, 0, 4'hF, COLOR, 8, 4);
    apply = 1'b1;
    @(posedge clk); #1;
    apply = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("pre-reset we", writeEnablePort, 1);
    chk("pre-reset addr", writeAddrPort, 5);
    reset = 1'b1;
    #1;
    chk("mid-fill reset we", writeEnablePort, 0);
    chk("mid-fill reset applied", applied, 1);
    chk("mid-fill reset addr", writeAddrPort, 0);
    chk("mid-fill reset mask", writeMaskPort, 0);
    chk("mid-fill reset data", writeDataPort, 0);
    @(posedge clk); #1;
    chk("reset held we", writeEnablePort, 0);
    reset = 1'b0;
    do_clear(1'b0, 0, 0, 0, 0, 4'hF, 0, -1, 1'b0);
    chk("restart count", got_addr.size(), 16);
    chk("restart applied cycle", done_cyc, 18);
    if (got_addr.size() > 0) chk("restart first addr", got_addr[0], 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/framebuffer_scissor_clear.md
FRAMEBUFFER_SCISSOR_CLEAR -- requirements
Module: framebuffer_scissor_clear

Interface
REQ-001 SHALL have parameter NUMBER_OF_PIXELS_PER_BEAT, default 2, pixels per RAM word (power of two, >=1).
REQ-002 SHALL have parameter NUMBER_OF_SUB_PIXELS, default 4, sub-pixels per pixel.
REQ-003 SHALL have parameter SUB_PIXEL_WIDTH, default 8, bits per sub-pixel.
REQ-004 SHALL have parameters X_BIT_WIDTH and Y_BIT_WIDTH, default 11 each, screen coordinate widths.
REQ-005 SHALL have parameter FRAMEBUFFER_SIZE_IN_PIXEL_LG, default 18, log2 of pixel capacity; MEM_ADDR_WIDTH = FRAMEBUFFER_SIZE_IN_PIXEL_LG - log2(PPB).
REQ-006 SHALL have ports:
- clk  in  1  clock; one clock domain, all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- apply  in  1  start clear; sampled only when applied=1.
- applied  out  1  1 = idle, 0 = clear in progress.
- confClearColor  in  PIXEL_WIDTH  fill colour, replicated per pixel.
- confEnableScissor  in  1  restrict clear to scissor rectangle.
- confScissorStartX/EndX  in  X_BIT_WIDTH  inclusive start, exclusive end.
- confScissorStartY/EndY  in  Y_BIT_WIDTH  inclusive start, exclusive end.
- confXResolution / confYResolution  in  X/Y_BIT_WIDTH  screen size in pixels.
- confMask  in  NUMBER_OF_SUB_PIXELS  per-sub-pixel write enable.
- writeEnablePort  out  1  RAM write strobe.
- writeAddrPort  out  MEM_ADDR_WIDTH  RAM word address.
- writeDataPort  out  PPB*PIXEL_WIDTH  RAM write data.
- writeMaskPort  out  PPB*NUMBER_OF_SUB_PIXELS  per-sub-pixel byte mask; bit i*NSP+k = pixel i, sub-pixel k.
- writeReady  in  1  RAM port grant; a write is accepted on writeEnablePort & writeReady.

Function
REQ-007 SHALL sample all conf* inputs on the cycle apply=1 and applied=1; later changes SHALL NOT affect the running clear.
REQ-008 SHALL implement states IDLE -> SETUP -> FILL -> IDLE; applied=1 only in IDLE.
REQ-009 SETUP SHALL clip region to [0,XRes)x[0,YRes); without scissor, region = whole screen.
REQ-010 If clipped region is empty (startX>=endX or startY>=endY), SETUP SHALL return to IDLE with zero writes.
REQ-011 applied SHALL go low the cycle after an accepted apply; the first writeEnablePort SHALL be asserted 2 cycles after apply.
REQ-012 FILL SHALL visit rows startY..endY-1 ascending; within a row, beats from floor(startX/PPB)*PPB up to endX-1, step PPB.
REQ-013 Word address SHALL be (rowBase + beatX) >> log2(PPB), rowBase = y*XRes, maintained by adding XRes per row (no multiplier).
REQ-014 Pixel i of a beat SHALL be enabled iff startX <= beatX+i < endX; its sub-pixel mask = confMask if enabled, else 0.
REQ-015 Sustained throughput SHALL be one word per cycle while writeReady=1; with writeReady=0, address/data/mask/enable SHALL hold unchanged.
REQ-016 After the last beat is accepted, next cycle SHALL be IDLE with applied=1 and writeEnablePort=0.
REQ-017 apply while applied=0 SHALL be ignored.
REQ-018 Address arithmetic SHALL wrap modulo 2^MEM_ADDR_WIDTH; XRes must be a multiple of PPB (caller precondition, not checked).

Reset
REQ-019 Reset SHALL force IDLE, applied=1, writeEnablePort=0, writeAddrPort=0, writeMaskPort=0, writeDataPort=0, immediately and asynchronously.
REQ-020 Reset mid-FILL SHALL abort the clear; no write after reset assertion; new apply accepted first cycle after release.

Structure
REQ-021 State enum and MEM_ADDR_WIDTH/PIXEL_WIDTH/mask-width constants SHALL live in shared package framebuffer_pkg.
REQ-022 Per-beat mask generation (REQ-014) SHALL be a combinational sub-module framebuffer_beat_mask_gen.

Verification (PPB=2, NSP=4, SPW=8, XRes=8, YRes=4, confMask=4'hF, writeReady=1 unless stated)
REQ-023 Scissor off, apply -> 16 writes, addr 0..15 consecutive, mask 8'hFF, data = colour twice, applied=1 cycle after last write.
REQ-024 Scissor (3,1)-(6,3) -> exactly 4 writes: addr 5 mask 8'hF0, 6 8'hFF, 9 8'hF0, 10 8'hFF.
REQ-025 Scissor (2,2)-(2,3) -> zero writes, applied=0 for 2 cycles, then 1.
REQ-026 Scissor off, writeReady low for cycles 3-5 of FILL -> outputs held, total still 16 distinct addresses, no duplicates.
REQ-027 confMask=4'b0101, scissor off -> every mask 8'h55.
REQ-028 Reset asserted after 5 writes -> writeEnablePort=0 same cycle; re-apply after release restarts from addr 0.
